fib_stream_sequencer: RTL and testbench
=======================================

// Module: fib_stream_sequencer
// PURPOSE
//  Sequential front/back end for the combinational Fibonacci stage.
//  On start, drives indices n_start .. n_start+count-1 into the stage (fib_n), one per accepted cycle.
//  Captures each returned value (fib_in) with its index into a small FIFO.
//  Presents captured values downstream on a valid/ready stream.
//  Flags and saturates indices whose result does not fit 32 bits (fib(0)=fib(1)=1, so fib(46)=2971215073 is the last valid value).
// PARAMETERS
//  DEPTH   4    FIFO entries, power of two, >=2
//  CNT_W   16   width of count / remaining-term counter
//  MAX_N   46   largest index whose fib fits in 32 bits
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request a sequence; sampled only in IDLE
//  n_start    in   32     first index; sampled with start
//  count      in   CNT_W  number of terms; sampled with start
//  busy       out  1      1 in RUN or DRAIN
//  done       out  1      one-cycle pulse when the sequence is fully delivered
//  fib_n      out  32     index driven to the Fibonacci stage (registered)
//  fib_in     in   32     combinational result for fib_n
//  out_valid  out  1      FIFO head valid
//  out_ready  in   1      downstream accepts head when out_valid&out_ready
//  out_data   out  32     fib value, or 32'hFFFF_FFFF if saturated
//  out_index  out  32     index of out_data
//  out_ovf    out  1      1 if out_index > MAX_N
// BEHAVIOUR
//  Reset: state=IDLE. busy=0, done=0, fib_n=0, FIFO empty, out_valid=0. out_data/index/ovf=0.
//  Reset mid-sequence aborts it. FIFO contents are discarded and no done pulse is issued.
//  States:
//   IDLE  -> RUN when start=1. Load fib_n=n_start, rem=count.
//             If count=0, go to DRAIN instead: FIFO is empty, so done pulses the next cycle.
//   RUN   Push cycle = rem!=0 and occupancy<DEPTH (registered occupancy, no bypass).
//         On a push cycle:
//           - write {fib_n, fib_in or sat, ovf} into the FIFO
//           - fib_n <= fib_n+1, rem <= rem-1
//         When the push makes rem 0, go to DRAIN.
//   DRAIN -> IDLE when the FIFO is empty, with done=1 in that transition cycle.
//  start while busy is ignored. n_start/count are not re-sampled.
//  Saturation: fib_n > MAX_N gives data 32'hFFFF_FFFF and ovf=1. fib_in is ignored for that entry.
//  fib_n increment wraps modulo 2^32. An index that wraps back to <=MAX_N is valid again.
//  Latency: start sampled at edge E0.
//   - first push at E1
//   - out_valid high after E1, i.e. 2 cycles after start asserted
//  FIFO:
//   - Push and pop in the same cycle are both honoured. Occupancy is unchanged.
//   - Full stalls RUN, with fib_n and rem held.
//   - out_* are stable while out_valid=1 and out_ready=0.
//  Pointers are log2(DEPTH) bits and wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.
// TESTING
//  1. n_start=0,count=5,out_ready=1 -> data 1,1,2,3,5; idx 0..4; ovf=0; one done pulse.
//  2. n_start=44,count=4 -> 1134903170, 1836311903, 2971215073, then FFFFFFFF with idx 47, ovf=1.
//  3. out_ready=0, count=6 -> exactly DEPTH entries pushed and fib_n held at n_start+4.
//     Release ready -> all 6 delivered in order.
//  4. count=0 -> busy for exactly 1 cycle, done pulses, no out_valid.
//  5. start pulsed again during RUN -> ignored; sequence and done unchanged.
//  6. rst asserted after 2 pushes -> next cycle out_valid=0, busy=0, no done.
//     New start then works from scratch.

Source files
------------

// File: rtl/fib_stream_sequencer.sv
// Drives a run of indices into a combinational Fibonacci stage and queues the results.
// Results that do not fit in 32 bits are saturated and flagged.
module fib_stream_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter int MAX_N = 46
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      n_start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      fib_n,
    input  logic [31:0]      fib_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [31:0]      out_index,
    output logic             out_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] rem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      index_mem [DEPTH];
    logic             ovf_mem [DEPTH];
    logic             push;
    logic             pop;
    logic             entry_ovf;
    logic [31:0]      entry_data;

    // Full is judged on registered occupancy only, so a same-cycle pop never frees a slot early.
    always_comb begin
        entry_ovf  = fib_n > 32'(MAX_N);
        entry_data = entry_ovf ? 32'hFFFF_FFFF : fib_in;
        push       = (state == RUN) && (rem != '0) && (occ < OCC_FULL);
        pop        = out_valid && out_ready;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (push && (rem == CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == '0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fib_n <= '0;
            rem   <= '0;
        end else if ((state == IDLE) && start) begin
            fib_n <= n_start;
            rem   <= count;
        end else if (push) begin
            fib_n <= fib_n + 32'd1;
            rem   <= rem - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: reads are masked until an entry has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr]  <= entry_data;
            index_mem[wr_ptr] <= fib_n;
            ovf_mem[wr_ptr]   <= entry_ovf;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (occ != '0);
        out_data  = out_valid ? data_mem[rd_ptr] : '0;
        out_index = out_valid ? index_mem[rd_ptr] : '0;
        out_ovf   = out_valid ? ovf_mem[rd_ptr] : 1'b0;
    end

endmodule

// File: tb/tb_fib_stream_sequencer.sv
// Scoreboard bench for fib_stream_sequencer with a behavioural Fibonacci stage.
// Expected entries are queued when a sequence is started and popped on each handshake.
module tb_fib_stream_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] n_start;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [31:0] fib_n;
    logic [31:0] fib_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_index;
    logic        out_ovf;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] idx;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   valid_cnt = 0;

    fib_stream_sequencer #(
        .DEPTH(4),
        .CNT_W(16),
        .MAX_N(46)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_start   (n_start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .fib_n     (fib_n),
        .fib_in    (fib_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fib(0)=fib(1)=1; out-of-range indices return junk the DUT must replace.
    function automatic logic [31:0] fibRef(input logic [31:0] n);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        if (n > 32'd46) return 32'hDEAD_0000 ^ n;
        a = 32'd1;
        b = 32'd1;
        for (int i = 2; i <= int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic exp_t makeExp(input logic [31:0] idx);
        exp_t e;
        e.idx  = idx;
        e.ovf  = (idx > 32'd46);
        e.data = e.ovf ? 32'hFFFF_FFFF : fibRef(idx);
        return e;
    endfunction

    always_comb fib_in = fibRef(fib_n);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (out_valid) valid_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", out_index, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_index", out_index, e.idx);
                checkOutput("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] n, input int cnt);
        @(posedge clk);
        #1;
        start   = 1'b1;
        n_start = n;
        count   = 16'(cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back(makeExp(n + 32'(i)));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles, input bit rand_ready);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", 32'(busy), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int d0;
        int b0;
        int v0;
        rst       = 1'b1;
        start     = 1'b0;
        n_start   = '0;
        count     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_fib_n", fib_n, 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        checkOutput("rst_index", out_index, 32'd0);
        checkOutput("rst_ovf", 32'(out_ovf), 32'd0);

        $display("[TB] basic sequence 0..4");
        d0 = done_cnt;
        applyStimulus(32'd0, 5);
        checkOutput("lat_busy", 32'(busy), 32'd1);
        checkOutput("lat_valid_e0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid_e1", 32'(out_valid), 32'd1);
        waitIdle(50, 1'b0);
        checkOutput("t1_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t1_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] saturation at 44..47");
        d0 = done_cnt;
        applyStimulus(32'd44, 4);
        waitIdle(50, 1'b0);
        checkOutput("t2_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] backpressure with full FIFO");
        out_ready = 1'b0;
        d0 = done_cnt;
        applyStimulus(32'd10, 6);
        repeat (10) @(negedge clk);
        checkOutput("t3_fib_n_held", fib_n, 32'd14);
        checkOutput("t3_valid", 32'(out_valid), 32'd1);
        checkOutput("t3_head_idx", out_index, 32'd10);
        checkOutput("t3_head_data", out_data, fibRef(32'd10));
        repeat (3) @(negedge clk);
        checkOutput("t3_stable_data", out_data, fibRef(32'd10));
        checkOutput("t3_stable_fib_n", fib_n, 32'd14);
        checkOutput("t3_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitIdle(50, 1'b0);
        checkOutput("t3_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] zero-length sequence");
        d0 = done_cnt;
        b0 = busy_cnt;
        v0 = valid_cnt;
        applyStimulus(32'd7, 0);
        waitIdle(10, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("t4_busy_cycles", 32'(busy_cnt - b0), 32'd1);
        checkOutput("t4_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t4_no_valid", 32'(valid_cnt - v0), 32'd0);

        $display("[TB] start ignored while running");
        d0 = done_cnt;
        applyStimulus(32'd20, 5);
        @(posedge clk);
        #1;
        start   = 1'b1;
        n_start = 32'd100;
        count   = 16'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle(50, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("t5_idle", 32'(busy), 32'd0);
        checkOutput("t5_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset mid-sequence");
        out_ready = 1'b0;
        d0 = done_cnt;
        applyStimulus(32'd5, 8);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_fib_n", fib_n, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t6_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("t6_still_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        applyStimulus(32'd3, 3);
        waitIdle(50, 1'b0);
        checkOutput("t6_restart_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] index wrap with random ready");
        d0 = done_cnt;
        applyStimulus(32'hFFFF_FFFE, 5);
        waitIdle(200, 1'b1);
        checkOutput("t7_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t7_drained", 32'(exp_q.size()), 32'd0);

        d0 = done_cnt;
        applyStimulus(32'd30, 12);
        waitIdle(300, 1'b1);
        checkOutput("t8_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("t8_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
